// File: rtl/data_memory_responder_if.sv
// Load/store bus between the CPU MEM stage (master) and the data memory (slave).
interface data_memory_responder_if;
  logic        READ;
  logic        WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        ERROR;

  modport master (
    output READ, WRITE, FUNC3, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT, ERROR
  );

  modport slave (
    input  READ, WRITE, FUNC3, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT, ERROR
  );
endinterface

// File: rtl/data_memory_responder.sv
// Byte-addressed data memory: one load/store at a time, BUSYWAIT stalls the CPU for
// LATENCY edges after acceptance, then a one-cycle DONE with registered READDATA/ERROR.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  data_memory_responder_if.slave mem_bus
);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            counter;
  logic                  lat_read;
  logic                  lat_write;
  logic [2:0]            lat_func3;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           read_data;
  logic                  error_q;

  logic [7:0]            mem [DEPTH];

  logic                  request;
  logic                  finish;
  logic                  acc_err;
  logic                  commit_load;
  logic                  commit_store;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [ADDR_WIDTH-1:0] addr3;
  logic [7:0]            b0;
  logic [7:0]            b1;
  logic [7:0]            b2;
  logic [7:0]            b3;
  logic [31:0]           load_val;
  logic                  unused_addr_bits;

  // Upper address bits are deliberately dropped so accesses wrap modulo the array size.
  assign unused_addr_bits = ^mem_bus.ADDRESS[31:ADDR_WIDTH];

  assign request      = mem_bus.READ | mem_bus.WRITE;
  assign finish       = (state == ST_BUSY) && (counter == 4'd0);
  assign commit_load  = lat_read && !acc_err;
  assign commit_store = finish && lat_write && !acc_err && !RESET;

  assign mem_bus.BUSYWAIT = ((state == ST_IDLE) && request) || (state == ST_BUSY);
  assign mem_bus.READDATA = read_data;
  assign mem_bus.ERROR    = error_q;

  assign addr1 = lat_addr + ADDR_WIDTH'(1);
  assign addr2 = lat_addr + ADDR_WIDTH'(2);
  assign addr3 = lat_addr + ADDR_WIDTH'(3);
  assign b0    = mem[lat_addr];
  assign b1    = mem[addr1];
  assign b2    = mem[addr2];
  assign b3    = mem[addr3];

  // Legality is judged only on the latched request so late input changes cannot flip it.
  always_comb begin
    acc_err = 1'b0;
    if (lat_read && lat_write) begin
      acc_err = 1'b1;
    end else if (lat_read) begin
      case (lat_func3)
        3'b000, 3'b100: acc_err = 1'b0;
        3'b001, 3'b101: acc_err = lat_addr[0];
        3'b010:         acc_err = |lat_addr[1:0];
        default:        acc_err = 1'b1;
      endcase
    end else if (lat_write) begin
      case (lat_func3)
        3'b000:  acc_err = 1'b0;
        3'b001:  acc_err = lat_addr[0];
        3'b010:  acc_err = |lat_addr[1:0];
        default: acc_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    load_val = '0;
    case (lat_func3)
      3'b000:  load_val = {{24{b0[7]}}, b0};
      3'b001:  load_val = {{16{b1[7]}}, b1, b0};
      3'b010:  load_val = {b3, b2, b1, b0};
      3'b100:  load_val = {24'd0, b0};
      3'b101:  load_val = {16'd0, b1, b0};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      counter   <= 4'd0;
      read_data <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request) begin
            state   <= ST_BUSY;
            counter <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            state   <= ST_DONE;
            error_q <= acc_err;
            if (commit_load) begin
              read_data <= load_val;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          error_q <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  // Request capture needs no reset: the latched copy is only consumed in BUSY.
  always_ff @(posedge CLK) begin
    if ((state == ST_IDLE) && request) begin
      lat_read  <= mem_bus.READ;
      lat_write <= mem_bus.WRITE;
      lat_func3 <= mem_bus.FUNC3;
      lat_addr  <= mem_bus.ADDRESS[ADDR_WIDTH-1:0];
      lat_wdata <= mem_bus.WRITEDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit_store) begin
      case (lat_func3)
        3'b000: begin
          mem[lat_addr] <= lat_wdata[7:0];
        end
        3'b001: begin
          mem[lat_addr] <= lat_wdata[7:0];
          mem[addr1]    <= lat_wdata[15:8];
        end
        3'b010: begin
          mem[lat_addr] <= lat_wdata[7:0];
          mem[addr1]    <= lat_wdata[15:8];
          mem[addr2]    <= lat_wdata[23:16];
          mem[addr3]    <= lat_wdata[31:24];
        end
        default: begin
        end
      endcase
    end
  end
endmodule
